pipe_trace_buffer: RTL and testbench
====================================

Name: pipe_trace_buffer

Overview:
Synthesizable, parametrised hardware trace unit for the pipelined RISC-V core. It replaces per-cycle printout of register, pipeline and PC state with on-chip capture of write-back events into a circular buffer. Capture stops a programmable number of samples after a PC-match or forced trigger. It attaches to the WB stage of the processor, and the captured window is drained through a valid/ready read port.

Parameters:
XLEN, 64, write-back data width
PC_W, 64, program-counter width
DEPTH, 16, trace entries; power of two, at least 4
CNT_W, $clog2(DEPTH), pointer width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
smp_valid  in  1  WB-stage event valid this cycle
smp_pc  in  PC_W  PC of retiring instruction
smp_instr  in  32  retiring instruction word
smp_rd  in  5  destination register
smp_wdata  in  XLEN  write-back data
smp_we  in  1  register write enable
smp_flush  in  1  event coincides with a flush
arm  in  1  one-cycle pulse: clear the buffer and start capture
trig_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  trigger PC
force_trig  in  1  one-cycle pulse: immediate trigger
post_cnt  in  CNT_W  samples to capture after the trigger sample
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  rd_data holds an unread entry
rd_data  out  PC_W+32+5+XLEN+2  {smp_pc, smp_instr, smp_rd, smp_wdata, smp_we, smp_flush}
level  out  CNT_W+1  entries held
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
triggered  out  1  trigger has occurred since the last arm
wrapped  out  1  pre-trigger capture overwrote old entries

Behaviour:
- Reset is asynchronous. All outputs go to 0, state=IDLE, and the pointers clear. Memory contents are don't-care.
- IDLE: smp_* is ignored. On arm, clear wr_ptr, rd_ptr, level, triggered and wrapped, then go to ARMED.
- ARMED: each smp_valid cycle writes the entry at wr_ptr and advances wr_ptr modulo DEPTH.
  - If level==DEPTH, rd_ptr also advances (the oldest entry is overwritten), level stays at DEPTH, and wrapped is set.
  - Otherwise level increments.
- Trigger condition: force_trig, or (trig_en and smp_valid and smp_pc==trig_pc).
  - The trigger sample itself is written.
  - triggered is set, the internal post counter loads post_cnt, and the next state is POST.
  - If post_cnt==0, the next state is DONE.
  - A force_trig with no smp_valid writes nothing.
- POST: capture continues with the same overwrite rule. Each written sample decrements the post counter. The write of the last sample (counter==1) moves the state to DONE.
- post_cnt is sampled only at the trigger. A value of DEPTH-1 or more is clamped to DEPTH-1, so the trigger entry always survives.
- DONE: capture is frozen. rd_valid = (level!=0). rd_data is combinational from mem[rd_ptr], with zero latency.
  - On rd_valid and rd_ready, rd_ptr increments with wrap and level decrements.
  - When level reaches 0 the state returns to IDLE.
  - Entries drain oldest first.
- rd_valid is 0 in all states other than DONE.
- arm in any state aborts the current operation and restarts ARMED with cleared pointers. arm has priority over a trigger in the same cycle; trigger checks start on the following cycle.
- A trigger while in POST or DONE is ignored.
- Signal source: smp_valid is driven from MEM/WB valid and is not suppressed by stall; flushed events are recorded with smp_flush=1.

Decomposition:
- Shared package pipe_trace_pkg:
  - state encodings TR_IDLE, TR_ARMED, TR_POST, TR_DONE
  - field widths and offsets for packing and unpacking rd_data
- One sub-module is natural: trace_ram, a single-write-port, asynchronous-read register array of DEPTH by entry width.
- The control FSM, pointers and counters live in pipe_trace_buffer.

Test Plan:
- Buffer fill: DEPTH=16, arm, trig_en=0, 10 samples, then force_trig with post_cnt=0 → state DONE, level=10, wrapped=0. The drain returns the 10 samples in order, and the state goes to IDLE after the 10th handshake.
- Wrap: arm, then 20 samples with PC=0x100 plus 4*i, trig_pc=0x14C (i=19), post_cnt=0 → level=16, wrapped=1. The drain yields PC 0x110 through 0x14C.
- Post-trigger window: trigger at i=5, post_cnt=3, 12 total samples → capture stops after i=8, level=9, and samples i=9 to 11 are absent.
- Clamp: post_cnt=15 with DEPTH=16, trigger after 4 samples → the drain contains exactly the trigger entry plus the 15 following samples.
- Drain backpressure: in DONE with rd_ready toggled 1,0,0,1 → rd_data holds stable while rd_ready is low, and level decrements only on handshake cycles.
- Async reset, and arm priority:
  - Assert rst mid-POST, asynchronously between clock edges → outputs go to 0 at once, state=IDLE.
  - Assert arm and force_trig in the same cycle → state becomes ARMED and triggered stays 0.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared encodings and rd_data field layout for the WB-stage trace buffer.
// Entry layout, MSB first: {pc, instr, rd, wdata, we, flush}.
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_e;

  localparam int INSTR_W = 32;
  localparam int RD_W    = 5;
  localparam int FLAG_W  = 2;

  localparam int OFF_FLUSH = 0;
  localparam int OFF_WE    = 1;
  localparam int OFF_WDATA = 2;

  function automatic int entry_w(input int xlen, input int pc_w);
    return pc_w + INSTR_W + RD_W + xlen + FLAG_W;
  endfunction

  function automatic int off_rd(input int xlen);
    return OFF_WDATA + xlen;
  endfunction

  function automatic int off_instr(input int xlen);
    return off_rd(xlen) + RD_W;
  endfunction

  function automatic int off_pc(input int xlen);
    return off_instr(xlen) + INSTR_W;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Sample, trigger-control and drain signals of the trace buffer.
// slave = trace unit side, master = core/debug side.
interface pipe_trace_buffer_if
  import pipe_trace_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH)
);
  localparam int EW = entry_w(XLEN, PC_W);

  logic              smp_valid;
  logic [PC_W-1:0]   smp_pc;
  logic [31:0]       smp_instr;
  logic [4:0]        smp_rd;
  logic [XLEN-1:0]   smp_wdata;
  logic              smp_we;
  logic              smp_flush;
  logic              arm;
  logic              trig_en;
  logic [PC_W-1:0]   trig_pc;
  logic              force_trig;
  logic [CNT_W-1:0]  post_cnt;
  logic              rd_ready;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic [CNT_W:0]    level;
  tr_state_e         state;
  logic              triggered;
  logic              wrapped;

  modport slave (
    input  smp_valid, smp_pc, smp_instr, smp_rd, smp_wdata, smp_we, smp_flush,
    input  arm, trig_en, trig_pc, force_trig, post_cnt, rd_ready,
    output rd_valid, rd_data, level, state, triggered, wrapped
  );

  modport master (
    output smp_valid, smp_pc, smp_instr, smp_rd, smp_wdata, smp_we, smp_flush,
    output arm, trig_en, trig_pc, force_trig, post_cnt, rd_ready,
    input  rd_valid, rd_data, level, state, triggered, wrapped
  );

endinterface

// File: rtl/trace_ram.sv
// DEPTH x W register array: one synchronous write port, combinational read port.
// Contents are not reset; validity is tracked by the owner's pointers.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular capture of WB events; stops post_cnt samples after a trigger, then drains
// oldest-first with zero-latency rd_data; rd_ready low holds the head entry in place.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  pipe_trace_buffer_if.slave bus
);

  localparam int EW = entry_w(XLEN, PC_W);
  localparam logic [CNT_W:0]   FULL     = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0]   LVL_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] PTR_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] POST_MAX = CNT_W'(DEPTH-1);

  tr_state_e        state_q, state_d;
  logic [CNT_W-1:0] wr_ptr, rd_ptr, post_q, post_ld;
  logic [CNT_W:0]   level_q;
  logic             triggered_q, wrapped_q;
  logic             trig_hit, wr_en, rd_fire;
  logic [EW-1:0]    wr_entry, rd_entry;

  // Clamp keeps the trigger entry inside the window once capture stops.
  assign post_ld = (bus.post_cnt >= POST_MAX) ? POST_MAX : bus.post_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    rd_fire  = 1'b0;
    trig_hit = 1'b0;
    if (bus.arm) begin
      state_d = TR_ARMED;
    end else begin
      case (state_q)
        TR_ARMED: begin
          wr_en    = bus.smp_valid;
          trig_hit = bus.force_trig |
                     (bus.trig_en & bus.smp_valid & (bus.smp_pc == bus.trig_pc));
          if (trig_hit) state_d = (post_ld == '0) ? TR_DONE : TR_POST;
        end
        TR_POST: begin
          wr_en = bus.smp_valid;
          if (wr_en && post_q == PTR_ONE) state_d = TR_DONE;
        end
        TR_DONE: begin
          rd_fire = bus.rd_ready && (level_q != '0);
          if (level_q == '0 || (rd_fire && level_q == LVL_ONE)) state_d = TR_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      post_q      <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else if (bus.arm) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      post_q      <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        // Full buffer: newest overwrites oldest, so the read side slides too.
        if (level_q == FULL) begin
          rd_ptr    <= rd_ptr + PTR_ONE;
          wrapped_q <= 1'b1;
        end else begin
          level_q <= level_q + LVL_ONE;
        end
      end
      if (trig_hit) begin
        triggered_q <= 1'b1;
        post_q      <= post_ld;
      end else if (wr_en && state_q == TR_POST) begin
        post_q <= post_q - PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        level_q <= level_q - LVL_ONE;
      end
    end
  end

  assign wr_entry = {bus.smp_pc, bus.smp_instr, bus.smp_rd, bus.smp_wdata,
                     bus.smp_we, bus.smp_flush};

  trace_ram #(.DEPTH(DEPTH), .W(EW), .AW(CNT_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.rd_valid  = (state_q == TR_DONE) && (level_q != '0);
  assign bus.rd_data   = bus.rd_valid ? rd_entry : '0;
  assign bus.level     = level_q;
  assign bus.state     = state_q;
  assign bus.triggered = triggered_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of the capture window.
module tb_pipe_trace_buffer;
  import pipe_trace_pkg::*;

  localparam int XLEN   = 64;
  localparam int PC_W   = 64;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 4;
  localparam int EW     = entry_w(XLEN, PC_W);
  localparam int OFF_PC = off_pc(XLEN);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_trace_buffer_if #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  pipe_trace_buffer #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: the capture window is just a bounded queue, oldest at the front.
  logic [EW-1:0] mq[$];
  int m_state, m_post;
  bit m_trig, m_wrap;

  function automatic logic [EW-1:0] cur_entry();
    return {bus.smp_pc, bus.smp_instr, bus.smp_rd, bus.smp_wdata, bus.smp_we, bus.smp_flush};
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_state = 0; m_post = 0; m_trig = 0; m_wrap = 0;
  endfunction

  function automatic void m_push();
    mq.push_back(cur_entry());
    if (mq.size() > DEPTH) begin
      void'(mq.pop_front());
      m_wrap = 1;
    end
  endfunction

  function automatic void m_step();
    if (rst) begin m_reset(); return; end
    if (bus.arm) begin m_reset(); m_state = 1; return; end
    case (m_state)
      1: begin
        if (bus.smp_valid) m_push();
        if (bus.force_trig || (bus.trig_en && bus.smp_valid && bus.smp_pc == bus.trig_pc)) begin
          m_trig  = 1;
          m_post  = (int'(bus.post_cnt) >= DEPTH-1) ? DEPTH-1 : int'(bus.post_cnt);
          m_state = (m_post == 0) ? 3 : 2;
        end
      end
      2: if (bus.smp_valid) begin
        m_push();
        m_post--;
        if (m_post == 0) m_state = 3;
      end
      3: begin
        if (mq.size() != 0 && bus.rd_ready) void'(mq.pop_front());
        if (mq.size() == 0) m_state = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [EW-1:0] m_head();
    return (m_state == 3 && mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.smp_valid = 0; bus.smp_pc = '0; bus.smp_instr = '0; bus.smp_rd = '0;
    bus.smp_wdata = '0; bus.smp_we = 0; bus.smp_flush = 0; bus.arm = 0;
    bus.trig_en = 0; bus.trig_pc = '0; bus.force_trig = 0; bus.post_cnt = '0;
    bus.rd_ready = 0;
  endtask

  task automatic drive_smp(input logic [PC_W-1:0] pc);
    bus.smp_valid = 1;
    bus.smp_pc    = pc;
    bus.smp_instr = $urandom;
    bus.smp_rd    = 5'($urandom);
    bus.smp_wdata = {$urandom, $urandom};
    bus.smp_we    = 1'($urandom);
    bus.smp_flush = 1'($urandom);
  endtask

  task automatic do_arm();
    idle_inputs();
    bus.arm = 1;
    tick();
    bus.arm = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    m_reset();
    #12;
    n_chk++; if (bus.state !== TR_IDLE || bus.level !== '0 || bus.rd_valid !== 0)
      $display("FAIL reset_state: state=%0d level=%0d rd_valid=%0b want 0/0/0", bus.state, bus.level, bus.rd_valid);
    else n_pass++;
    n_chk++; if (bus.triggered !== 0 || bus.wrapped !== 0 || bus.rd_data !== '0)
      $display("FAIL reset_flags: trig=%0b wrap=%0b data=%h want 0", bus.triggered, bus.wrapped, bus.rd_data);
    else n_pass++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_fill();
    do_arm();
    n_chk++; if (bus.state !== TR_ARMED)
      $display("FAIL fill_armed: state=%0d want 1", bus.state);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin drive_smp(64'($urandom)); tick(); end
    idle_inputs();
    bus.force_trig = 1;
    tick();
    bus.force_trig = 0;
    n_chk++; if (bus.state !== TR_DONE || bus.level !== 5'd10 || bus.wrapped !== 0 || bus.triggered !== 1)
      $display("FAIL fill_done: state=%0d level=%0d wrap=%0b trig=%0b want 3/10/0/1",
               bus.state, bus.level, bus.wrapped, bus.triggered);
    else n_pass++;
    bus.rd_ready = 1;
    for (int k = 0; k < 10; k++) begin
      n_chk++; if (bus.rd_valid !== 1 || bus.rd_data !== m_head())
        $display("FAIL fill_drain[%0d]: valid=%0b data=%h want 1/%h", k, bus.rd_valid, bus.rd_data, m_head());
      else n_pass++;
      tick();
    end
    n_chk++; if (bus.state !== TR_IDLE || bus.rd_valid !== 0 || bus.level !== '0)
      $display("FAIL fill_idle: state=%0d valid=%0b level=%0d want 0/0/0", bus.state, bus.rd_valid, bus.level);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_arm();
    bus.trig_en = 1; bus.trig_pc = 64'h14C; bus.post_cnt = 0;
    for (int i = 0; i < 20; i++) begin drive_smp(64'h100 + 64'(4*i)); tick(); end
    bus.smp_valid = 0;
    n_chk++; if (bus.state !== TR_DONE || bus.level !== 5'd16 || bus.wrapped !== 1)
      $display("FAIL wrap_done: state=%0d level=%0d wrap=%0b want 3/16/1", bus.state, bus.level, bus.wrapped);
    else n_pass++;
    bus.rd_ready = 1;
    for (int k = 0; k < 16; k++) begin
      n_chk++; if (bus.rd_data[OFF_PC +: PC_W] !== 64'h110 + 64'(4*k) || bus.rd_data !== m_head())
        $display("FAIL wrap_drain[%0d]: pc=%h want %h", k, bus.rd_data[OFF_PC +: PC_W], 64'h110 + 64'(4*k));
      else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_post_window();
    do_arm();
    bus.trig_en = 1; bus.trig_pc = 64'h214; bus.post_cnt = 3;
    for (int i = 0; i < 12; i++) begin drive_smp(64'h200 + 64'(4*i)); tick(); end
    bus.smp_valid = 0;
    n_chk++; if (bus.state !== TR_DONE || bus.level !== 5'd9 || bus.triggered !== 1)
      $display("FAIL post_done: state=%0d level=%0d trig=%0b want 3/9/1", bus.state, bus.level, bus.triggered);
    else n_pass++;
    bus.rd_ready = 1;
    for (int k = 0; k < 9; k++) begin
      n_chk++; if (bus.rd_data[OFF_PC +: PC_W] !== 64'h200 + 64'(4*k) || bus.rd_data !== m_head())
        $display("FAIL post_drain[%0d]: pc=%h want %h", k, bus.rd_data[OFF_PC +: PC_W], 64'h200 + 64'(4*k));
      else n_pass++;
      tick();
    end
    n_chk++; if (bus.state !== TR_IDLE)
      $display("FAIL post_idle: state=%0d want 0", bus.state);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_clamp();
    do_arm();
    bus.trig_en = 1; bus.trig_pc = 64'h310; bus.post_cnt = 4'd15;
    for (int i = 0; i < 24; i++) begin drive_smp(64'h300 + 64'(4*i)); tick(); end
    bus.smp_valid = 0;
    n_chk++; if (bus.state !== TR_DONE || bus.level !== 5'd16)
      $display("FAIL clamp_done: state=%0d level=%0d want 3/16", bus.state, bus.level);
    else n_pass++;
    bus.rd_ready = 1;
    for (int k = 0; k < 16; k++) begin
      n_chk++; if (bus.rd_data[OFF_PC +: PC_W] !== 64'h310 + 64'(4*k) || bus.rd_data !== m_head())
        $display("FAIL clamp_drain[%0d]: pc=%h want %h", k, bus.rd_data[OFF_PC +: PC_W], 64'h310 + 64'(4*k));
      else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [EW-1:0] held;
    int exp_lvl = 5;
    do_arm();
    for (int i = 0; i < 5; i++) begin drive_smp(64'($urandom)); tick(); end
    idle_inputs();
    bus.force_trig = 1;
    tick();
    bus.force_trig = 0;
    for (int s = 0; s < 4; s++) begin
      held = bus.rd_data;
      bus.rd_ready = pat[s];
      tick();
      if (pat[s]) exp_lvl--;
      n_chk++; if (bus.level !== 5'(exp_lvl) || bus.rd_data !== m_head() || (!pat[s] && bus.rd_data !== held))
        $display("FAIL bp_step[%0d]: level=%0d data=%h want %0d/%h", s, bus.level, bus.rd_data, exp_lvl, m_head());
      else n_pass++;
    end
    idle_inputs();
    do_arm();
  endtask

  task automatic test_async_reset();
    do_arm();
    for (int i = 0; i < 3; i++) begin drive_smp(64'($urandom)); tick(); end
    bus.force_trig = 1; bus.post_cnt = 5;
    tick();
    bus.force_trig = 0;
    tick();
    n_chk++; if (bus.state !== TR_POST)
      $display("FAIL areset_pre: state=%0d want 2", bus.state);
    else n_pass++;
    idle_inputs();
    #3 rst = 1;
    #1;
    m_reset();
    n_chk++; if (bus.state !== TR_IDLE || bus.level !== '0 || bus.triggered !== 0 || bus.rd_valid !== 0 || bus.rd_data !== '0)
      $display("FAIL areset: state=%0d level=%0d trig=%0b valid=%0b want all 0",
               bus.state, bus.level, bus.triggered, bus.rd_valid);
    else n_pass++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_arm_priority();
    idle_inputs();
    bus.arm = 1; bus.force_trig = 1; bus.trig_en = 1; bus.trig_pc = 64'h40;
    drive_smp(64'h40);
    tick();
    idle_inputs();
    n_chk++; if (bus.state !== TR_ARMED || bus.triggered !== 0 || bus.level !== '0)
      $display("FAIL arm_prio: state=%0d trig=%0b level=%0d want 1/0/0", bus.state, bus.triggered, bus.level);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_arm();
      bus.trig_en = 1; bus.trig_pc = 64'h420;
      for (int c = 0; c < 90; c++) begin
        if ($urandom_range(3) != 0) drive_smp(64'h400 + 64'(4*$urandom_range(15)));
        else bus.smp_valid = 0;
        bus.force_trig = ($urandom_range(24) == 0);
        bus.arm        = ($urandom_range(60) == 0);
        bus.post_cnt   = 4'($urandom);
        bus.rd_ready   = 1'($urandom);
        tick();
        n_chk++; if (bus.state !== tr_state_e'(m_state) || bus.level !== 5'(mq.size()) ||
                     bus.triggered !== m_trig || bus.wrapped !== m_wrap ||
                     bus.rd_valid !== (m_state == 3 && mq.size() != 0) || bus.rd_data !== m_head())
          $display("FAIL rand[%0d.%0d]: state=%0d/%0d level=%0d/%0d trig=%0b/%0b wrap=%0b/%0b valid=%0b",
                   r, c, bus.state, m_state, bus.level, mq.size(), bus.triggered, m_trig,
                   bus.wrapped, m_wrap, bus.rd_valid);
        else n_pass++;
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_post_window();
    test_clamp();
    test_backpressure();
    test_async_reset();
    test_arm_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
